// File: rtl/topk_heap_controller_if.sv
// Host key stream plus level-1 sorting_node handshake bundle for topk_heap_controller.
// slave is the controller's view; master is the host/node-chain view.
interface topk_heap_controller_if #(
  parameter int unsigned WIDTH = 15
);
  logic           in_valid;
  logic [WIDTH:0] in_data;
  logic           in_ready;
  logic           drain_req;
  logic           out_valid;
  logic [WIDTH:0] out_data;
  logic           out_reject;
  logic           out_last;
  logic           busy;
  logic           initialize;
  logic           update_root;
  logic           root_addr;
  logic [WIDTH:0] root_q;
  logic [WIDTH:0] root_data;
  logic           root_wren;

  modport slave (
    input  in_valid, in_data, drain_req, root_data, root_wren,
    output in_ready, out_valid, out_data, out_reject, out_last, busy,
           initialize, update_root, root_addr, root_q
  );

  modport master (
    output in_valid, in_data, drain_req, root_data, root_wren,
    input  in_ready, out_valid, out_data, out_reject, out_last, busy,
           initialize, update_root, root_addr, root_q
  );
endinterface

// File: rtl/topk_heap_controller.sv
// Top-K heap sequencing controller: owns the root record, clears the node chain and paces sift-down waves.
// Define TOPK_COUNT_EN to add the occupancy counter and zero-fill suppression during drain.
module topk_heap_controller #(
  parameter int unsigned LEVELS      = 2,
  parameter int unsigned WIDTH       = 15,
  parameter int unsigned NODE_PERIOD = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  topk_heap_controller_if.slave bus
`ifdef TOPK_COUNT_EN
  ,
  output logic [LEVELS+1:0]    count
`endif
);

  localparam int unsigned KEY_W        = WIDTH + 1;
  localparam int unsigned CAP          = (32'd1 << (LEVELS + 1)) - 32'd1;
  localparam int unsigned CLEAR_CYCLES = CAP + 1;
  localparam int unsigned TMR_MAX      = (CLEAR_CYCLES > NODE_PERIOD) ? CLEAR_CYCLES : NODE_PERIOD;
  localparam int unsigned TMR_W        = $clog2(TMR_MAX);
  localparam int unsigned IDX_W        = LEVELS + 1;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_INIT,
    S_IDLE,
    S_SIFT,
    S_DRAIN_EMIT,
    S_DRAIN_WAIT
  } state_t;

  state_t           state;
  logic [TMR_W-1:0] tmr;
  logic [IDX_W-1:0] emit_idx;
  logic [KEY_W-1:0] root;
  logic [KEY_W-1:0] out_data_q;
  logic             ready_q;
  logic             out_valid_q;
  logic             out_reject_q;
  logic             out_last_q;
  logic             busy_q;
  logic             init_q;
  logic             update_q;
  logic             show_c;
  logic             last_emit_c;

`ifdef TOPK_COUNT_EN
  localparam int unsigned CNT_W = LEVELS + 2;
  logic [CNT_W-1:0] count_q;

  // Zero-fill entries drain first, so only the last count_q emits carry real keys.
  assign show_c = (CNT_W'(emit_idx) + count_q) >= CNT_W'(CAP);
  assign count  = count_q;
`else
  assign show_c = 1'b1;
`endif

  assign last_emit_c = (emit_idx == IDX_W'(CAP - 1));

  // drain_req wins over a same-cycle key, so it also withdraws ready.
  assign bus.in_ready    = ready_q & ~bus.drain_req;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_reject  = out_reject_q;
  assign bus.out_last    = out_last_q;
  assign bus.busy        = busy_q;
  assign bus.initialize  = init_q;
  assign bus.update_root = update_q;
  assign bus.root_addr   = 1'b0;
  assign bus.root_q      = root;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_CLEAR;
      tmr          <= '0;
      emit_idx     <= '0;
      root         <= '0;
      out_data_q   <= '0;
      ready_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_reject_q <= 1'b0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b1;
      init_q       <= 1'b0;
      update_q     <= 1'b0;
`ifdef TOPK_COUNT_EN
      count_q      <= '0;
`endif
    end else begin
      out_valid_q  <= 1'b0;
      out_reject_q <= 1'b0;
      out_last_q   <= 1'b0;
      init_q       <= 1'b0;
      update_q     <= 1'b0;

      // Sift-down write-back from level 1; overridden below where the controller owns the root.
      if (bus.root_wren && (state != S_CLEAR)) begin
        root <= bus.root_data;
      end

      case (state)
        S_CLEAR: begin
          root    <= '0;
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
`ifdef TOPK_COUNT_EN
          count_q <= '0;
`endif
          if (tmr == TMR_W'(CLEAR_CYCLES - 1)) begin
            tmr    <= '0;
            init_q <= 1'b1;
            state  <= S_INIT;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end

        S_INIT: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state   <= S_IDLE;
        end

        S_IDLE: begin
          if (bus.drain_req) begin
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            emit_idx <= '0;
            state    <= S_DRAIN_EMIT;
          end else if (bus.in_valid) begin
            out_valid_q <= 1'b1;
            if (bus.in_data > root) begin
              root       <= bus.in_data;
              out_data_q <= root;
              update_q   <= 1'b1;
              ready_q    <= 1'b0;
              busy_q     <= 1'b1;
              tmr        <= '0;
              state      <= S_SIFT;
`ifdef TOPK_COUNT_EN
              if (count_q != CNT_W'(CAP)) begin
                count_q <= count_q + CNT_W'(1);
              end
`endif
            end else begin
              out_data_q   <= bus.in_data;
              out_reject_q <= 1'b1;
            end
          end
        end

        S_SIFT: begin
          if (tmr == TMR_W'(NODE_PERIOD - 1)) begin
            tmr     <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state   <= S_IDLE;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end

        S_DRAIN_EMIT: begin
          // An all-ones root sinks to the bottom, pulling the next minimum up.
          out_valid_q <= show_c;
          out_last_q  <= last_emit_c & show_c;
          out_data_q  <= root;
          root        <= '1;
          update_q    <= 1'b1;
          tmr         <= '0;
          state       <= S_DRAIN_WAIT;
        end

        S_DRAIN_WAIT: begin
          if (tmr == TMR_W'(NODE_PERIOD - 1)) begin
            tmr <= '0;
            if (last_emit_c) begin
              state <= S_CLEAR;
            end else begin
              emit_idx <= emit_idx + IDX_W'(1);
              state    <= S_DRAIN_EMIT;
            end
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end

        default: begin
          tmr   <= '0;
          state <= S_CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_topk_heap_controller.sv
// Scoreboard bench for topk_heap_controller: top-K multiset reference model plus a behavioural node chain.
module tb_topk_heap_controller;

  localparam int LEVELS = 2;
  localparam int WIDTH  = 15;
  localparam int NP     = 4;
  localparam int N      = (1 << (LEVELS + 1)) - 1;

  typedef struct {
    int data;
    bit rej;
    bit last;
  } exp_t;

  logic clk;
  logic rst;
  topk_heap_controller_if #(.WIDTH(WIDTH)) bus ();
`ifdef TOPK_COUNT_EN
  logic [LEVELS+1:0] count;
`endif

  topk_heap_controller #(.LEVELS(LEVELS), .WIDTH(WIDTH), .NODE_PERIOD(NP)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus)
`ifdef TOPK_COUNT_EN
    ,
    .count (count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   ov_cnt   = 0;
  int   upd_cnt  = 0;
  exp_t sb[$];

  // Reference: the heap is just a multiset of the N kept keys.
  int ref_heap[N];
  int ref_cnt;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int ref_min_idx();
    int idx = 0;
    for (int i = 1; i < N; i++) if (ref_heap[i] < ref_heap[idx]) idx = i;
    return idx;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) ref_heap[i] = 0;
    ref_cnt = 0;
  endtask

  task automatic model_insert(input int k, output bit ins);
    int idx;
    exp_t e;
    idx = ref_min_idx();
    if (k > ref_heap[idx]) begin
      e = '{data: ref_heap[idx], rej: 1'b0, last: 1'b0};
      ref_heap[idx] = k;
      if (ref_cnt < N) ref_cnt++;
      ins = 1'b1;
    end else begin
      e = '{data: k, rej: 1'b1, last: 1'b0};
      ins = 1'b0;
    end
    sb.push_back(e);
  endtask

  task automatic model_drain();
    int q[$];
    exp_t e;
    for (int i = 0; i < N; i++) q.push_back(ref_heap[i]);
    q.sort();
    for (int i = 0; i < N; i++) begin
`ifdef TOPK_COUNT_EN
      if (i < N - ref_cnt) continue;
`endif
      e = '{data: q[i], rej: 1'b0, last: (i == N - 1)};
      sb.push_back(e);
    end
    model_clear();
  endtask

  // Behavioural stand-in for the sorting_node chain below the root.
  int below[N-1];
  initial begin
    int pend_cnt;
    int pend_val;
    int idx;
    int r;
    pend_cnt = 0;
    pend_val = 0;
    bus.root_wren = 1'b0;
    bus.root_data = '0;
    forever begin
      @(negedge clk);
      bus.root_wren = 1'b0;
      if (rst || bus.initialize) begin
        for (int i = 0; i < N - 1; i++) below[i] = 0;
        pend_cnt = 0;
      end else begin
        if (pend_cnt > 0) begin
          pend_cnt--;
          if (pend_cnt == 0) begin
            bus.root_wren = 1'b1;
            bus.root_data = (WIDTH + 1)'(pend_val);
          end
        end
        if (bus.update_root) begin
          r   = int'(bus.root_q);
          idx = 0;
          for (int i = 1; i < N - 1; i++) if (below[i] < below[idx]) idx = i;
          if (r <= below[idx]) pend_val = r;
          else begin
            pend_val   = below[idx];
            below[idx] = r;
          end
          pend_cnt = 2;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every output pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.update_root) upd_cnt++;
      if (bus.out_valid) begin
        ov_cnt++;
        if (sb.size() == 0) begin
          chk("out_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("out_data", bus.out_data, e.data);
          chk("out_reject", bus.out_reject, e.rej);
          chk("out_last", bus.out_last, e.last);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    int init_n  = 0;
    int init_at = 0;
    int rdy_at  = 0;
    int ov0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.drain_req = 1'b0;
    rst = 1'b1;
    step(1);
    sb.delete();
    step(2);
    rst = 1'b0;
    model_clear();
    ov0 = ov_cnt;
    chk("rst_busy", bus.busy, 1);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_root_addr", bus.root_addr, 0);
    for (int c = 1; c <= 12; c++) begin
      if (bus.initialize) begin
        init_n++;
        init_at = c;
      end
      if (bus.in_ready && rdy_at == 0) rdy_at = c;
      if (c < 12) step(1);
    end
    chk("init_pulses", init_n, 1);
    chk("init_cycle", init_at, (1 << (LEVELS + 1)) + 1);
    chk("ready_cycle", rdy_at, (1 << (LEVELS + 1)) + 2);
    chk("rst_root_q", bus.root_q, 0);
    chk("rst_idle_busy", bus.busy, 0);
    chk("rst_no_out", ov_cnt - ov0, 0);
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!bus.in_ready && t < 50) begin
      step(1);
      t++;
    end
    if (!bus.in_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic send_key(input int k, input bit follow);
    bit ins;
    int low;
    wait_ready();
    model_insert(k, ins);
    bus.in_valid = 1'b1;
    bus.in_data  = (WIDTH + 1)'(k);
    step(1);
    bus.in_valid = 1'b0;
    if (!follow) return;
    chk("ready_after_accept", bus.in_ready, ins ? 0 : 1);
    if (ins) begin
      chk("root_new", bus.root_q, k);
      low = 0;
      while (!bus.in_ready && low < 20) begin
        low++;
        step(1);
      end
      chk("ready_low_cycles", low, NP);
      chk("root_settled_min", bus.root_q, ref_heap[ref_min_idx()]);
    end
  endtask

  task automatic start_drain();
    wait_ready();
`ifdef TOPK_COUNT_EN
    chk("count", count, ref_cnt);
`endif
    model_drain();
    bus.drain_req = 1'b1;
    step(1);
    bus.drain_req = 1'b0;
  endtask

  task automatic do_drain();
    int t = 0;
    start_drain();
    chk("drain_busy", bus.busy, 1);
    while (bus.busy && t < 300) begin
      step(1);
      t++;
    end
    chk("drain_done", bus.busy, 0);
    chk("drain_root_zero", bus.root_q, 0);
    chk("drain_sb_empty", sb.size(), 0);
  endtask

  initial begin
    int u0;
    int seq9[9] = '{9, 2, 7, 4, 8, 1, 6, 3, 5};
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.drain_req = 1'b0;
    model_clear();
    step(2);

    // Reset release timing.
    do_reset();

    // Insert into an empty heap evicts a zero.
    u0 = upd_cnt;
    send_key(5, 1'b1);
    chk("upd_pulses", upd_cnt - u0, 1);
    chk("sb_empty_after_5", sb.size(), 0);

    // Full heap with minimum 10: ties and smaller keys reject back-to-back.
    do_reset();
    for (int k = 10; k <= 16; k++) send_key(k, 1'b1);
    u0 = upd_cnt;
    send_key(10, 1'b1);
    send_key(3, 1'b1);
    chk("reject_no_upd", upd_cnt - u0, 0);
    do_drain();

    // Nine-key sequence, then ordered drain.
    do_reset();
    foreach (seq9[i]) send_key(seq9[i], 1'b1);
    do_drain();

    // Partial fill, then drain.
    do_reset();
    send_key(4, 1'b1);
    send_key(2, 1'b1);
    do_drain();

    // Randomized traffic with occasional drains.
    do_reset();
    for (int i = 0; i < 80; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 5) do_drain();
      else if (r < 20) step($urandom_range(1, 4));
      else send_key($urandom_range(0, 40), 1'b1);
    end
    do_drain();

    // Reset in the middle of a sift wave.
    send_key(30, 1'b0);
    step(1);
    do_reset();

    // Reset in the middle of a drain.
    send_key(12, 1'b1);
    send_key(25, 1'b1);
    send_key(18, 1'b1);
    start_drain();
    step(8);
    do_reset();
    chk("final_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
